// File: rtl/ether_rx_pkg.sv
// Shared types for the Ethernet receive interface: stream widths, the
// write-side FSM states and the layout of one stored FIFO word.
package ether_rx_pkg;

  localparam int DATA_W = 64;
  localparam int KEEP_W = DATA_W / 8;
  localparam int WORD_W = 1 + KEEP_W + DATA_W;

  typedef enum logic [1:0] {
    RESYNC = 2'd0,
    IDLE   = 2'd1,
    STORE  = 2'd2,
    DROP   = 2'd3
  } wr_state_t;

  typedef struct packed {
    logic              last;
    logic [KEEP_W-1:0] keep;
    logic [DATA_W-1:0] data;
  } fifo_word_t;

endpackage

// File: rtl/ether_rx_frame_ram.sv
// Simple dual-port frame store: one write port and one registered read port,
// written so that synthesis maps the array onto block RAM.
module ether_rx_frame_ram
  import ether_rx_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  fifo_word_t        wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output fifo_word_t        rd_data
);

  fifo_word_t mem [2**ADDR_W];

  // Write port: one word per cycle at wr_addr.
  // NOTE: the array has no reset; resetting it would stop it mapping onto
  // block RAM, and no word is ever read before the pointers say it was written.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses <= so every register samples the
    // values from before the edge, whatever the statement order.
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: output register loads only on an accepted read and clears on
  // reset so the consumer sees zeros before the first word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/ether_rx_if.sv
// Store-and-forward receive buffer between the 10G MAC RX stream and the
// deserializer. Beats are written speculatively from wr_ptr; a good TLAST
// publishes the frame by moving commit_ptr, a bad or overflowing frame is
// rolled back to commit_ptr and counted. The reader only ever sees words
// between rd_ptr and commit_ptr.
module ether_rx_if
  import ether_rx_pkg::*;
#(
  parameter int TX_RX_S_AXIS_WIDTH = DATA_W,
  parameter int FIFO_DEPTH_LOG2    = 9,
  parameter int DROP_CNT_WIDTH     = 16
) (
  input  logic                            RX_ACLK,
  input  logic                            RX_ARESETN,
  input  logic [TX_RX_S_AXIS_WIDTH-1:0]   RX_S_AXIS_TDATA,
  input  logic [TX_RX_S_AXIS_WIDTH/8-1:0] RX_S_AXIS_TKEEP,
  input  logic                            RX_S_AXIS_TUSER,
  input  logic                            RX_S_AXIS_TLAST,
  input  logic                            RX_S_AXIS_TVALID,
  input  logic                            RD_EN,
  output logic [TX_RX_S_AXIS_WIDTH-1:0]   DESERIALIZED_DATA,
  output logic                            DATA_VALID,
  output logic                            FRAME_LAST,
  output logic [TX_RX_S_AXIS_WIDTH/8-1:0] LAST_KEEP,
  output logic                            DATA_EMPTY,
  output logic [DROP_CNT_WIDTH-1:0]       DROP_CNT
);

  localparam int PTR_W = FIFO_DEPTH_LOG2;

  typedef logic [PTR_W-1:0] ptr_t;

  wr_state_t                 state;
  ptr_t                      wr_ptr;
  ptr_t                      commit_ptr;
  ptr_t                      rd_ptr;
  ptr_t                      wr_ptr_inc;
  logic                      full;
  logic                      empty;
  logic                      beat_open;
  logic                      wr_en;
  logic                      rd_fire;
  logic                      data_valid;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_inc;
  fifo_word_t                wr_word;
  fifo_word_t                rd_word;

  // Pointers wrap modulo the RAM depth; one slot stays unused so that
  // full and empty are distinguishable. The full test uses the rd_ptr from
  // before any read in the same cycle.
  assign wr_ptr_inc = wr_ptr + PTR_W'(1);
  assign full       = (wr_ptr_inc == rd_ptr);
  assign empty      = (rd_ptr == commit_ptr);

  // A beat is a candidate for storage only while a frame is being collected.
  assign beat_open = RX_S_AXIS_TVALID && ((state == IDLE) || (state == STORE));
  assign wr_en     = beat_open && !full;
  assign rd_fire   = RD_EN && !empty;

  assign wr_word.last = RX_S_AXIS_TLAST;
  assign wr_word.keep = RX_S_AXIS_TKEEP;
  assign wr_word.data = RX_S_AXIS_TDATA;

  // Dropped-frame counter holds at all-ones instead of wrapping.
  assign drop_cnt_inc = (drop_cnt == '1) ? drop_cnt : drop_cnt + DROP_CNT_WIDTH'(1);

  // Write FSM: collects beats, publishes good frames and rewinds bad or
  // overflowing ones. RESYNC waits for an idle cycle so a frame already in
  // flight at reset release is never mistaken for a frame start.
  always_ff @(posedge RX_ACLK or negedge RX_ARESETN) begin
    if (!RX_ARESETN) begin
      state      <= RESYNC;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      drop_cnt   <= '0;
    end else begin
      unique case (state)
        RESYNC: begin
          if (!RX_S_AXIS_TVALID) begin
            state <= IDLE;
          end
        end

        IDLE, STORE: begin
          if (RX_S_AXIS_TVALID) begin
            if (full) begin
              // No room for this beat: the frame cannot complete, so rewind
              // now and discard the remainder.
              wr_ptr <= commit_ptr;
              if (RX_S_AXIS_TLAST) begin
                drop_cnt <= drop_cnt_inc;
                state    <= IDLE;
              end else begin
                state <= DROP;
              end
            end else if (RX_S_AXIS_TLAST) begin
              state <= IDLE;
              if (RX_S_AXIS_TUSER) begin
                wr_ptr   <= commit_ptr;
                drop_cnt <= drop_cnt_inc;
              end else begin
                wr_ptr     <= wr_ptr_inc;
                commit_ptr <= wr_ptr_inc;
              end
            end else begin
              wr_ptr <= wr_ptr_inc;
              state  <= STORE;
            end
          end
        end

        DROP: begin
          if (RX_S_AXIS_TVALID && RX_S_AXIS_TLAST) begin
            drop_cnt <= drop_cnt_inc;
            state    <= IDLE;
          end
        end

        default: begin
          state <= RESYNC;
        end
      endcase
    end
  end

  // Read side: advance rd_ptr on each accepted request and flag the word
  // that the RAM output register presents on the next cycle.
  always_ff @(posedge RX_ACLK or negedge RX_ARESETN) begin
    if (!RX_ARESETN) begin
      rd_ptr     <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= rd_fire;
      if (rd_fire) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  ether_rx_frame_ram #(
    .ADDR_W (PTR_W)
  ) u_frame_ram (
    .clk     (RX_ACLK),
    .rst_n   (RX_ARESETN),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (wr_word),
    .rd_en   (rd_fire),
    .rd_addr (rd_ptr),
    .rd_data (rd_word)
  );

  assign DESERIALIZED_DATA = rd_word.data;
  assign FRAME_LAST        = rd_word.last;
  assign LAST_KEEP         = rd_word.keep;
  assign DATA_VALID        = data_valid;
  assign DATA_EMPTY        = empty;
  assign DROP_CNT          = drop_cnt;

endmodule

// File: tb/tb_ether_rx_if.sv
// Self-checking bench for ether_rx_if: a directed vector table, hand-written
// corner sequences and randomized traffic compared against a frame-level
// queue model.
module tb_ether_rx_if;

  localparam int N      = 4;
  localparam int DEPTH  = 1 << N;
  localparam int USABLE = DEPTH - 1;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic [63:0] tdata  = '0;
  logic [7:0]  tkeep  = '0;
  logic        tuser  = 1'b0;
  logic        tlast  = 1'b0;
  logic        tvalid = 1'b0;
  logic        rd_en  = 1'b0;
  logic [63:0] dout;
  logic        dvalid;
  logic        flast;
  logic [7:0]  lkeep;
  logic        dempty;
  logic [15:0] dcnt;

  always #5 clk = ~clk;

  ether_rx_if #(
    .TX_RX_S_AXIS_WIDTH (64),
    .FIFO_DEPTH_LOG2    (N),
    .DROP_CNT_WIDTH     (16)
  ) dut (
    .RX_ACLK           (clk),
    .RX_ARESETN        (rst_n),
    .RX_S_AXIS_TDATA   (tdata),
    .RX_S_AXIS_TKEEP   (tkeep),
    .RX_S_AXIS_TUSER   (tuser),
    .RX_S_AXIS_TLAST   (tlast),
    .RX_S_AXIS_TVALID  (tvalid),
    .RD_EN             (rd_en),
    .DESERIALIZED_DATA (dout),
    .DATA_VALID        (dvalid),
    .FRAME_LAST        (flast),
    .LAST_KEEP         (lkeep),
    .DATA_EMPTY        (dempty),
    .DROP_CNT          (dcnt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_reads  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Frame-level reference: a queue of readable words and a queue holding the
  // frame in progress. Occupancy is simply the sum of both queue sizes.
  // ---------------------------------------------------------------------
  typedef struct packed {
    logic        last;
    logic [7:0]  keep;
    logic [63:0] data;
  } word_t;

  localparam int M_SYNC    = 0;
  localparam int M_RUN     = 1;
  localparam int M_DISCARD = 2;

  word_t m_frame[$];
  word_t m_fifo[$];
  int    m_mode;
  int    m_drops;
  bit    m_valid;
  word_t m_out;

  task automatic model_reset();
    m_frame.delete();
    m_fifo.delete();
    m_mode  = M_SYNC;
    m_drops = 0;
    m_valid = 1'b0;
    m_out   = '0;
  endtask

  task automatic model_step(input bit tv, input bit tl, input bit tu,
                            input logic [63:0] d, input logic [7:0] k, input bit rd);
    bit is_full;
    is_full = (m_fifo.size() + m_frame.size()) == USABLE;
    m_valid = 1'b0;
    if (rd && m_fifo.size() != 0) begin
      m_out   = m_fifo.pop_front();
      m_valid = 1'b1;
    end
    case (m_mode)
      M_SYNC: if (!tv) m_mode = M_RUN;
      M_RUN: begin
        if (tv) begin
          if (is_full) begin
            m_frame.delete();
            if (tl) m_drops++;
            else    m_mode = M_DISCARD;
          end else begin
            m_frame.push_back('{last: tl, keep: k, data: d});
            if (tl) begin
              if (tu) m_drops++;
              else foreach (m_frame[i]) m_fifo.push_back(m_frame[i]);
              m_frame.delete();
            end
          end
        end
      end
      default: begin
        if (tv && tl) begin
          m_drops++;
          m_mode = M_RUN;
        end
      end
    endcase
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic step(input bit tv, input bit tl, input bit tu,
                      input logic [63:0] d, input logic [7:0] k, input bit rd);
    tvalid = tv;
    tlast  = tl;
    tuser  = tu;
    tdata  = d;
    tkeep  = k;
    rd_en  = rd;
    model_step(tv, tl, tu, d, k, rd);
    @(posedge clk);
    #1;
    check("valid", dvalid, m_valid);
    if (m_valid) begin
      check("data", dout, m_out.data);
      check("frame_last", flast, m_out.last);
      if (m_out.last) check("last_keep", lkeep, m_out.keep);
    end
    check("empty", dempty, m_fifo.size() == 0);
    check("drop_cnt", dcnt, m_drops);
    if (dvalid) n_reads++;
  endtask

  function automatic bit pick_rd(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return $urandom_range(0, 99) < 40;
  endfunction

  task automatic send_frame(input int len, input bit bad, input logic [7:0] lk, input int rd_mode);
    for (int i = 0; i < len; i++) begin
      bit last;
      last = (i == len - 1);
      step(1'b1, last, bad && last, {$urandom, $urandom}, last ? lk : 8'hFF, pick_rd(rd_mode));
    end
  endtask

  task automatic idle(input int cycles, input int rd_mode);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'b0, '0, '0, pick_rd(rd_mode));
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEPTH && m_fifo.size() != 0; i++) idle(1, 1);
    idle(1, 1);
    check("drain_empty", dempty, 1'b1);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    tvalid = 1'b0;
    tlast  = 1'b0;
    tuser  = 1'b0;
    rd_en  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", dout, 64'h0);
    check("rst_valid", dvalid, 1'b0);
    check("rst_last", flast, 1'b0);
    check("rst_keep", lkeep, 8'h0);
    check("rst_empty", dempty, 1'b1);
    check("rst_drop", dcnt, 16'h0);
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------------------------------------------------------------
  // Directed vector table: good 3-word frame then a single-beat frame.
  // Expected columns are the outputs one cycle after the row is applied.
  // ---------------------------------------------------------------------
  typedef struct {
    bit          tv, tl, tu;
    logic [63:0] d;
    logic [7:0]  k;
    bit          rd;
    bit          ev, el;
    logic [7:0]  ek;
    logic [63:0] ed;
    bit          ee;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{0, 0, 0, 64'h0,        8'h00, 0, 0, 0, 8'h00, 64'h0,        1};
    tbl[1]  = '{1, 0, 0, 64'hA0A0_0000, 8'hFF, 0, 0, 0, 8'h00, 64'h0,        1};
    tbl[2]  = '{1, 0, 0, 64'hA1A1_1111, 8'hFF, 0, 0, 0, 8'h00, 64'h0,        1};
    tbl[3]  = '{1, 1, 0, 64'hA2A2_2222, 8'h0F, 0, 0, 0, 8'h00, 64'h0,        0};
    tbl[4]  = '{0, 0, 0, 64'h0,        8'h00, 1, 1, 0, 8'h00, 64'hA0A0_0000, 0};
    tbl[5]  = '{0, 0, 0, 64'h0,        8'h00, 1, 1, 0, 8'h00, 64'hA1A1_1111, 0};
    tbl[6]  = '{0, 0, 0, 64'h0,        8'h00, 1, 1, 1, 8'h0F, 64'hA2A2_2222, 1};
    tbl[7]  = '{0, 0, 0, 64'h0,        8'h00, 1, 0, 0, 8'h00, 64'h0,        1};
    tbl[8]  = '{1, 1, 0, 64'hB0B0_B0B0, 8'h01, 0, 0, 0, 8'h00, 64'h0,        0};
    tbl[9]  = '{0, 0, 0, 64'h0,        8'h00, 1, 1, 1, 8'h01, 64'hB0B0_B0B0, 1};
    tbl[10] = '{0, 0, 0, 64'h0,        8'h00, 0, 0, 0, 8'h00, 64'h0,        1};

    #1;
    do_reset();

    for (int i = 0; i < 11; i++) begin
      tvalid = tbl[i].tv;
      tlast  = tbl[i].tl;
      tuser  = tbl[i].tu;
      tdata  = tbl[i].d;
      tkeep  = tbl[i].k;
      rd_en  = tbl[i].rd;
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_valid", i), dvalid, tbl[i].ev);
      check($sformatf("tbl%0d_empty", i), dempty, tbl[i].ee);
      check($sformatf("tbl%0d_drop", i), dcnt, 16'h0);
      if (tbl[i].ev) begin
        check($sformatf("tbl%0d_data", i), dout, tbl[i].ed);
        check($sformatf("tbl%0d_last", i), flast, tbl[i].el);
        if (tbl[i].el) check($sformatf("tbl%0d_keep", i), lkeep, tbl[i].ek);
      end
    end

    // Bad frame followed by a good 2-word frame.
    do_reset();
    idle(1, 0);
    n_reads = 0;
    send_frame(4, 1'b1, 8'hFF, 0);
    send_frame(2, 1'b0, 8'h3F, 0);
    drain();
    check("bad_drop_cnt", dcnt, 16'd1);
    check("bad_reads", n_reads, 2);

    // Overflow: 20-word frame into a 15-word FIFO, then a 5-word frame.
    do_reset();
    idle(1, 0);
    n_reads = 0;
    send_frame(20, 1'b0, 8'hFF, 0);
    check("ovf_drop_cnt", dcnt, 16'd1);
    check("ovf_empty", dempty, 1'b1);
    send_frame(5, 1'b0, 8'h07, 0);
    drain();
    check("ovf_reads", n_reads, 5);
    check("ovf_drop_after", dcnt, 16'd1);

    // Exactly full: a 15-word frame fits, a 16th word would not.
    do_reset();
    idle(1, 0);
    n_reads = 0;
    send_frame(USABLE, 1'b0, 8'h01, 0);
    check("fill_drop_cnt", dcnt, 16'd0);
    drain();
    check("fill_reads", n_reads, USABLE);

    // Reset asserted after word 2 of 6, released while beats continue.
    do_reset();
    idle(1, 0);
    send_frame(2, 1'b0, 8'hFF, 0);
    tvalid = 1'b1;
    tlast  = 1'b0;
    tdata  = 64'hDEAD_0002;
    rst_n  = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_empty", dempty, 1'b1);
    check("midrst_drop", dcnt, 16'd0);
    tdata = 64'hDEAD_0003;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    step(1'b1, 1'b0, 1'b0, 64'hDEAD_0004, 8'hFF, 1'b0);
    step(1'b1, 1'b1, 1'b0, 64'hDEAD_0005, 8'h0F, 1'b0);
    check("tail_empty", dempty, 1'b1);
    idle(1, 0);
    n_reads = 0;
    send_frame(3, 1'b0, 8'h1F, 0);
    drain();
    check("midrst_reads", n_reads, 3);
    check("midrst_drop_after", dcnt, 16'd0);

    // Randomized traffic: continuous reads first, then sparse reads so the
    // FIFO fills, overflows and the pointers wrap many times.
    do_reset();
    idle(1, 1);
    for (int f = 0; f < 160; f++) begin
      int mode;
      int len;
      mode = (f < 80) ? 1 : 2;
      len  = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 18) : $urandom_range(1, 8);
      send_frame(len, $urandom_range(0, 7) == 0, 8'($urandom_range(1, 255)), mode);
      idle($urandom_range(0, 2), mode);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
